address_bank_ctrl: RTL and testbench

ADDRESS_BANK_CTRL -- requirements
Module: address_bank_ctrl

---
 rtl/address_bank_ctrl.sv | 79 +++++++
 tb/tb_address_bank_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/address_bank_ctrl.sv
// Rotating address-bank controller: the writer commits full banks and the reader releases
// consumed banks. It tracks the bank pointers, the count of pending banks and sticky misuse errors.
module address_bank_ctrl #(
    parameter int unsigned BANKS = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             chng_wrt_shft,
    input  logic             chng_rd_shft,
    input  logic             clr_err,
    output logic [PTR_W-1:0] wrt_bank,
    output logic [PTR_W-1:0] rd_bank,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             wrt_shft_enabler,
    output logic             rd_shft_enabler,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BANKS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BANKS - 1);

    logic rd_acc_c;
    logic wr_acc_c;
    logic ovf_set_c;
    logic unf_set_c;

    // Explicit wrap keeps the pointers inside 0..BANKS-1 when BANKS is not a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty            = (count == '0);
    assign full             = (count == CNT_FULL);
    assign wrt_shft_enabler = wrt_bank[0];
    assign rd_shft_enabler  = rd_bank[0];

    // A read that is accepted in the same cycle frees a slot, so a write is allowed even when full.
    always_comb begin
        rd_acc_c  = chng_rd_shft && !empty;
        wr_acc_c  = chng_wrt_shft && (!full || rd_acc_c);
        ovf_set_c = chng_wrt_shft && !wr_acc_c;
        unf_set_c = chng_rd_shft && !rd_acc_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrt_bank <= '0;
            rd_bank  <= '0;
            count    <= '0;
        end else begin
            if (wr_acc_c) wrt_bank <= ptr_inc(wrt_bank);
            if (rd_acc_c) rd_bank  <= ptr_inc(rd_bank);
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky errors: a new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (ovf_set_c)    ovf_err <= 1'b1;
            else if (clr_err) ovf_err <= 1'b0;
            if (unf_set_c)    unf_err <= 1'b1;
            else if (clr_err) unf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_address_bank_ctrl.sv
// Bench for address_bank_ctrl: four instances (BANKS 2,3,4,5) share the stimulus. Each instance
// is checked against a per-instance model built from a read pointer and a pending count.
module tb_address_bank_ctrl;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wq = 1'b0;
    logic rq = 1'b0;
    logic clr = 1'b0;

    int o_wr[NI], o_rd[NI], o_cnt[NI];
    int o_emp[NI], o_ful[NI], o_we[NI], o_re[NI], o_ovf[NI], o_unf[NI];

    int n_tests = 0;
    int n_fail  = 0;

    int m_rd[NI], m_cnt[NI], m_ovf[NI], m_unf[NI];

    always #5 clk = ~clk;

    function automatic int nb(input int k);
        return k + 2;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned B = g + 2;
        localparam int unsigned P = (g == 0) ? 1 : (g == 3) ? 3 : 2;
        logic [P-1:0] wb, rb;
        logic [P:0]   cnt;
        logic         emp, ful, we, re, ovf, unf;

        address_bank_ctrl #(.BANKS(B), .PTR_W(P)) u_dut (
            .clock            (clk),
            .reset_n          (rst_n),
            .chng_wrt_shft    (wq),
            .chng_rd_shft     (rq),
            .clr_err          (clr),
            .wrt_bank         (wb),
            .rd_bank          (rb),
            .count            (cnt),
            .empty            (emp),
            .full             (ful),
            .wrt_shft_enabler (we),
            .rd_shft_enabler  (re),
            .ovf_err          (ovf),
            .unf_err          (unf)
        );

        always_comb begin
            o_wr[g]  = int'(wb);
            o_rd[g]  = int'(rb);
            o_cnt[g] = int'(cnt);
            o_emp[g] = int'(emp);
            o_ful[g] = int'(ful);
            o_we[g]  = int'(we);
            o_re[g]  = int'(re);
            o_ovf[g] = int'(ovf);
            o_unf[g] = int'(unf);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_rd[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
    endtask

    // The write pointer is never stored: it is derived as (rd + count) mod BANKS.
    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            bit rok, wok;
            rok = rq && (m_cnt[k] > 0);
            wok = wq && ((m_cnt[k] < nb(k) - 1) || rok);
            if (wq && !wok)    m_ovf[k] = 1;
            else if (clr)      m_ovf[k] = 0;
            if (rq && !rok)    m_unf[k] = 1;
            else if (clr)      m_unf[k] = 0;
            m_cnt[k] = m_cnt[k] + int'(wok) - int'(rok);
            m_rd[k]  = (m_rd[k] + int'(rok)) % nb(k);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            int ew;
            ew = (m_rd[k] + m_cnt[k]) % nb(k);
            check($sformatf("i%0d_wrt_bank", k), o_wr[k], ew);
            check($sformatf("i%0d_rd_bank", k), o_rd[k], m_rd[k]);
            check($sformatf("i%0d_count", k), o_cnt[k], m_cnt[k]);
            check($sformatf("i%0d_empty", k), o_emp[k], int'(m_cnt[k] == 0));
            check($sformatf("i%0d_full", k), o_ful[k], int'(m_cnt[k] == nb(k) - 1));
            check($sformatf("i%0d_wrt_en", k), o_we[k], ew % 2);
            check($sformatf("i%0d_rd_en", k), o_re[k], m_rd[k] % 2);
            check($sformatf("i%0d_ovf", k), o_ovf[k], m_ovf[k]);
            check($sformatf("i%0d_unf", k), o_unf[k], m_unf[k]);
        end
    endtask

    task automatic cycle(input bit w, input bit r, input bit c);
        @(negedge clk);
        wq = w; rq = r; clr = c;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        // Requests presented under reset must be ignored across a rising edge.
        wq = 1'b1; rq = 1'b1; clr = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        wq = 1'b0; rq = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // One write; afterwards the two-bank instance is full.
        cycle(1, 0, 0);
        check("d_b2_wrt_bank", o_wr[0], 1);
        check("d_b2_full", o_ful[0], 1);
        check("d_b2_wrt_en", o_we[0], 1);
        // Write while the two-bank instance is full raises ovf; a clear drops it.
        cycle(1, 0, 0);
        check("d_b2_ovf", o_ovf[0], 1);
        check("d_b2_wrt_hold", o_wr[0], 1);
        cycle(0, 0, 1);
        check("d_b2_ovf_clr", o_ovf[0], 0);

        // Empty instances: a read sets unf; write and read together on empty accepts only the write.
        async_reset();
        cycle(0, 1, 0);
        check("d_b3_unf", o_unf[1], 1);
        check("d_b3_rd_bank", o_rd[1], 0);
        cycle(1, 1, 0);
        check("d_b3_cnt_simul_empty", o_cnt[1], 1);
        // A clear together with a new error event leaves the flag set.
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        check("d_b3_set_wins", o_unf[1], 1);
        cycle(0, 0, 1);

        // Three-bank sequence: 2 writes, 2 reads, 2 writes.
        async_reset();
        repeat (2) cycle(1, 0, 0);
        repeat (2) cycle(0, 1, 0);
        repeat (2) cycle(1, 0, 0);
        check("d_b3_wrap_wrt", o_wr[1], 1);
        check("d_b3_wrap_rd", o_rd[1], 2);
        check("d_b3_wrap_full", o_ful[1], 1);

        // Four-bank instance at count 3: a simultaneous write and read keeps the count.
        async_reset();
        repeat (3) cycle(1, 0, 0);
        cycle(1, 1, 0);
        check("d_b4_simul_cnt", o_cnt[2], 3);
        check("d_b4_simul_wrt", o_wr[2], 0);
        check("d_b4_simul_ovf", o_ovf[2], 0);

        // Reset between edges with banks committed.
        cycle(0, 1, 0);
        async_reset();
        check("d_b4_rst_empty", o_emp[2], 1);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 63) == 0) async_reset();
            else cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
